// File: rtl/drive_pkg.sv
// Shared drive codes: junction direction codes, H-bridge motor codes, speed selects
// and the junction sequencer state encoding.
package drive_pkg;

   localparam logic [2:0] DIR_STRAIGHT = 3'b000;
   localparam logic [2:0] DIR_LEFT     = 3'b001;
   localparam logic [2:0] DIR_RIGHT    = 3'b010;
   localparam logic [2:0] DIR_BACK     = 3'b011;
   localparam logic [2:0] DIR_STOP     = 3'b100;

   localparam logic [1:0] MOT_COAST = 2'b00;
   localparam logic [1:0] MOT_FWD   = 2'b01;
   localparam logic [1:0] MOT_REV   = 2'b10;
   localparam logic [1:0] MOT_BRAKE = 2'b11;

   localparam logic [1:0] SPD_OFF         = 2'b00;
   localparam logic [1:0] SPD_FULL        = 2'b01;
   localparam logic [1:0] SPD_NINETY      = 2'b10;
   localparam logic [1:0] SPD_NINETY_FAST = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_ROTATE = 3'd2,
      ST_SETTLE = 3'd3,
      ST_DONE   = 3'd4,
      ST_HALT   = 3'd5
   } seqState_t;

   // STOP and the unused codes 101-111 all end the maneuver in HALT.
   function automatic logic isHaltDir(input logic [2:0] d);
      return d[2];
   endfunction

endpackage

// File: rtl/pulse_edge_counter.sv
// Encoder pulse counter: 2-flop synchroniser, rising-edge detect and an 8-bit
// saturating count with synchronous clear.
module pulse_edge_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pulse,
   input  logic       clr,
   input  logic       en,
   output logic [7:0] count
);

   logic       sync1Reg, sync2Reg, prevReg;
   logic [7:0] countReg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1Reg <= 1'b0;
         sync2Reg <= 1'b0;
         prevReg  <= 1'b0;
         countReg <= 8'd0;
      end else begin
         sync1Reg <= pulse;
         sync2Reg <= sync1Reg;
         prevReg  <= sync2Reg;
         if (clr)
            countReg <= 8'd0;
         else if (en && sync2Reg && !prevReg && countReg != 8'hFF)
            countReg <= countReg + 8'd1;
      end
   end

   assign count = countReg;

endmodule

// File: rtl/junction_sequencer.sv
// Junction maneuver sequencer: overrides the line-follow drive and runs one
// straight/left/right/back/stop maneuver. JUNCTION_SEQ_TIMEOUT_EN adds the watchdog.
module junction_sequencer
   import drive_pkg::*;
#(
   parameter int PULSES_CLEAR   = 20,
   parameter int PULSES_TURN    = 40,
   parameter int PULSES_BACK    = 80,
   parameter int SETTLE_CYCLES  = 2_500_000,
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] dir,
   input  logic       abort,
   input  logic       clear,
   input  logic       shaftPulseL,
   input  logic       shaftPulseR,
   output logic       busy,
   output logic       ovrEn,
   output logic [1:0] motL,
   output logic [1:0] motR,
   output logic [1:0] spdSel,
   output logic       done,
   output logic       timeout,
   output logic       halted
);

   localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

   seqState_t           stateReg, stateNext;
   logic [2:0]          dirReg;
   logic                haltPendReg, haltSet;
   logic                reachedLReg, reachedRReg;
   logic                clrCnt, counting, wdExpire;
   logic [7:0]          countL, countR, target;
   logic [SETTLE_W-1:0] settleCntReg;

   assign counting = (stateReg == ST_CLEAR) || (stateReg == ST_ROTATE);
   assign target   = (stateReg == ST_CLEAR) ? 8'(PULSES_CLEAR) :
                     (dirReg == DIR_BACK)   ? 8'(PULSES_BACK)  : 8'(PULSES_TURN);

   pulse_edge_counter cntL (
      .clk(clk), .rst_n(rst_n), .pulse(shaftPulseL), .clr(clrCnt), .en(counting), .count(countL)
   );
   pulse_edge_counter cntR (
      .clk(clk), .rst_n(rst_n), .pulse(shaftPulseR), .clr(clrCnt), .en(counting), .count(countR)
   );

`ifdef JUNCTION_SEQ_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wdCntReg;

   // Runs continuously across CLEAR and ROTATE; restarts every time the FSM leaves them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wdCntReg <= '0;
      else if (!counting)
         wdCntReg <= '0;
      else
         wdCntReg <= wdCntReg + 1'b1;
   end

   assign wdExpire = counting && (wdCntReg == WD_LAST);
`else
   // Watchdog absent; the parameter is still accepted so instantiations stay uniform.
   assign wdExpire = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

   always_comb begin
      stateNext = stateReg;
      clrCnt    = 1'b0;
      haltSet   = 1'b0;
      case (stateReg)
         ST_IDLE: if (start) begin
            clrCnt    = 1'b1;
            stateNext = isHaltDir(dir) ? ST_SETTLE : ST_CLEAR;
         end
         ST_CLEAR: if (wdExpire) begin
            haltSet   = 1'b1;
            stateNext = ST_SETTLE;
         end else if (reachedLReg && reachedRReg) begin
            clrCnt    = 1'b1;
            stateNext = (dirReg == DIR_STRAIGHT) ? ST_SETTLE : ST_ROTATE;
         end
         ST_ROTATE: if (wdExpire) begin
            haltSet   = 1'b1;
            stateNext = ST_SETTLE;
         end else if (reachedLReg && reachedRReg) begin
            stateNext = ST_SETTLE;
         end
         ST_SETTLE: if (settleCntReg == SETTLE_LAST)
            stateNext = haltPendReg ? ST_HALT : ST_DONE;
         ST_DONE:  stateNext = ST_IDLE;
         ST_HALT:  if (clear) stateNext = ST_IDLE;
         default:  stateNext = ST_IDLE;
      endcase
      if (abort && stateReg != ST_IDLE)
         stateNext = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg     <= ST_IDLE;
         dirReg       <= DIR_STRAIGHT;
         haltPendReg  <= 1'b0;
         reachedLReg  <= 1'b0;
         reachedRReg  <= 1'b0;
         settleCntReg <= '0;
      end else begin
         stateReg <= stateNext;
         if (stateReg == ST_IDLE && start) begin
            dirReg      <= dir;
            haltPendReg <= isHaltDir(dir);
         end else if (haltSet) begin
            haltPendReg <= 1'b1;
         end
         // Registered compare: a wheel brakes one cycle after its count hits target.
         reachedLReg  <= counting && !clrCnt && (countL >= target);
         reachedRReg  <= counting && !clrCnt && (countR >= target);
         settleCntReg <= (stateReg == ST_SETTLE) ? settleCntReg + 1'b1 : '0;
      end
   end

   always_comb begin
      motL   = MOT_COAST;
      motR   = MOT_COAST;
      spdSel = SPD_OFF;
      case (stateReg)
         ST_CLEAR: begin
            motL   = reachedLReg ? MOT_BRAKE : MOT_FWD;
            motR   = reachedRReg ? MOT_BRAKE : MOT_FWD;
            spdSel = SPD_FULL;
         end
         ST_ROTATE: begin
            motL   = reachedLReg ? MOT_BRAKE : ((dirReg == DIR_LEFT) ? MOT_REV : MOT_FWD);
            motR   = reachedRReg ? MOT_BRAKE : ((dirReg == DIR_LEFT) ? MOT_FWD : MOT_REV);
            spdSel = SPD_NINETY_FAST;
         end
         ST_SETTLE, ST_DONE, ST_HALT: begin
            motL = MOT_BRAKE;
            motR = MOT_BRAKE;
         end
         default: ;
      endcase
      if (abort && stateReg != ST_IDLE) begin
         motL   = MOT_BRAKE;
         motR   = MOT_BRAKE;
         spdSel = SPD_OFF;
      end
   end

   assign busy    = (stateReg != ST_IDLE);
   assign ovrEn   = busy;
   assign done    = (stateReg == ST_DONE) && !abort;
   assign timeout = wdExpire && !abort;
   assign halted  = (stateReg == ST_HALT);

endmodule

// File: tb/tb_junction_sequencer.sv
// Directed bench for junction_sequencer with shortened settle and watchdog times.
module tb_junction_sequencer;
   import drive_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, abort = 1'b0, clear = 1'b0;
   logic [2:0] dir = 3'b000;
   logic       shaftPulseL = 1'b0, shaftPulseR = 1'b0;
   logic       busy, ovrEn, done, timeout, halted;
   logic [1:0] motL, motR, spdSel;

   int checks = 0;
   int failures = 0;
   int doneCount = 0;
   int timeoutCount = 0;

   junction_sequencer #(
      .PULSES_CLEAR(20), .PULSES_TURN(40), .PULSES_BACK(80),
      .SETTLE_CYCLES(8), .TIMEOUT_CYCLES(1000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .abort(abort), .clear(clear),
      .shaftPulseL(shaftPulseL), .shaftPulseR(shaftPulseR),
      .busy(busy), .ovrEn(ovrEn), .motL(motL), .motR(motR), .spdSel(spdSel),
      .done(done), .timeout(timeout), .halted(halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done === 1'b1) doneCount++;
      if (timeout === 1'b1) timeoutCount++;
   end

   initial begin
      #500_000;
      $display("FAIL global_time_limit reached, bench did not finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulses(input int nL, input int nR);
      int n;
      n = (nL > nR) ? nL : nR;
      for (int i = 0; i < n; i++) begin
         shaftPulseL = (i < nL);
         shaftPulseR = (i < nR);
         tick(2);
         shaftPulseL = 1'b0;
         shaftPulseR = 1'b0;
         tick(2);
      end
   endtask

   task automatic startMan(input logic [2:0] d);
      start = 1'b1;
      dir   = d;
      tick(1);
      start = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      checks++; if (busy !== 1'b0 || ovrEn !== 1'b0) begin failures++; $display("FAIL reset_busy busy=%b ovrEn=%b expected 0/0", busy, ovrEn); end
      checks++; if ({motL, motR, spdSel} !== 6'b0) begin failures++; $display("FAIL reset_motors got=%b expected=000000", {motL, motR, spdSel}); end
      checks++; if ({done, timeout, halted} !== 3'b0) begin failures++; $display("FAIL reset_flags got=%b expected=000", {done, timeout, halted}); end
      rst_n = 1'b1;
      tick(2);
      $display("reset: busy=%b mot=%b/%b spd=%b", busy, motL, motR, spdSel);
   endtask

   task automatic test_straight;
      int d0;
      d0 = doneCount;
      startMan(DIR_STRAIGHT);
      checks++; if (busy !== 1'b1 || ovrEn !== 1'b1) begin failures++; $display("FAIL straight_busy busy=%b ovrEn=%b expected 1/1", busy, ovrEn); end
      checks++; if (motL !== MOT_FWD || motR !== MOT_FWD || spdSel !== SPD_FULL) begin failures++; $display("FAIL straight_clear mot=%b/%b spd=%b expected 01/01 01", motL, motR, spdSel); end
      pulses(19, 19);
      checks++; if (motL !== MOT_FWD || motR !== MOT_FWD) begin failures++; $display("FAIL straight_19 mot=%b/%b expected 01/01", motL, motR); end
      pulses(1, 1);
      checks++; if (motL !== MOT_BRAKE || motR !== MOT_BRAKE) begin failures++; $display("FAIL straight_brake mot=%b/%b expected 11/11", motL, motR); end
      tick(1);
      tick(7);
      checks++; if (spdSel !== SPD_OFF || motL !== MOT_BRAKE || done !== 1'b0) begin failures++; $display("FAIL straight_settle spd=%b motL=%b done=%b expected 00 11 0", spdSel, motL, done); end
      tick(1);
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL straight_done got=%b expected=1", done); end
      tick(1);
      checks++; if (busy !== 1'b0 || done !== 1'b0 || doneCount != d0 + 1) begin failures++; $display("FAIL straight_idle busy=%b done=%b pulses=%0d expected 0 0 1", busy, done, doneCount - d0); end
      $display("straight: done pulses=%0d", doneCount - d0);
   endtask

   task automatic test_left;
      startMan(DIR_LEFT);
      pulses(20, 20);
      tick(1);
      checks++; if (motL !== MOT_REV || motR !== MOT_FWD || spdSel !== SPD_NINETY_FAST) begin failures++; $display("FAIL left_rotate mot=%b/%b spd=%b expected 10/01 11", motL, motR, spdSel); end
      pulses(30, 39);
      shaftPulseR = 1'b1;
      tick(2);
      shaftPulseR = 1'b0;
      tick(1);
      checks++; if (motR !== MOT_FWD) begin failures++; $display("FAIL left_r_at_count motR=%b expected=01", motR); end
      tick(1);
      checks++; if (motR !== MOT_BRAKE || motL !== MOT_REV) begin failures++; $display("FAIL left_r_brake mot=%b/%b expected 10/11", motL, motR); end
      tick(1);
      pulses(10, 0);
      checks++; if (motL !== MOT_BRAKE || spdSel !== SPD_NINETY_FAST) begin failures++; $display("FAIL left_l_brake motL=%b spd=%b expected 11 11", motL, spdSel); end
      tick(1);
      checks++; if (spdSel !== SPD_OFF || busy !== 1'b1) begin failures++; $display("FAIL left_settle spd=%b busy=%b expected 00 1", spdSel, busy); end
      tick(8);
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL left_done got=%b expected=1", done); end
      tick(1);
      $display("left: busy=%b after done", busy);
   endtask

   task automatic test_back_skew;
      startMan(DIR_BACK);
      pulses(20, 20);
      tick(1);
      checks++; if (motL !== MOT_FWD || motR !== MOT_REV) begin failures++; $display("FAIL back_rotate mot=%b/%b expected 01/10", motL, motR); end
      pulses(80, 40);
      checks++; if (motL !== MOT_BRAKE || motR !== MOT_REV) begin failures++; $display("FAIL back_skew mot=%b/%b expected 11/10", motL, motR); end
      pulses(0, 40);
      checks++; if (motL !== MOT_BRAKE || motR !== MOT_BRAKE) begin failures++; $display("FAIL back_both mot=%b/%b expected 11/11", motL, motR); end
      tick(9);
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL back_done got=%b expected=1", done); end
      tick(1);
      $display("back: busy=%b after done", busy);
   endtask

   task automatic test_stop_invalid;
      logic [2:0] codes [2];
      int d0;
      codes[0] = 3'b100;
      codes[1] = 3'b110;
      for (int k = 0; k < 2; k++) begin
         d0 = doneCount;
         startMan(codes[k]);
         checks++; if (busy !== 1'b1 || motL !== MOT_BRAKE || spdSel !== SPD_OFF) begin failures++; $display("FAIL stop_settle dir=%b busy=%b motL=%b spd=%b expected 1 11 00", codes[k], busy, motL, spdSel); end
         tick(7);
         checks++; if (halted !== 1'b0) begin failures++; $display("FAIL stop_early_halt dir=%b halted=%b expected=0", codes[k], halted); end
         tick(1);
         checks++; if (halted !== 1'b1 || busy !== 1'b1 || motR !== MOT_BRAKE) begin failures++; $display("FAIL stop_halt dir=%b halted=%b busy=%b motR=%b expected 1 1 11", codes[k], halted, busy, motR); end
         tick(3);
         checks++; if (doneCount != d0 || halted !== 1'b1) begin failures++; $display("FAIL stop_nodone dir=%b done_pulses=%0d halted=%b expected 0 1", codes[k], doneCount - d0, halted); end
         clear = 1'b1;
         tick(1);
         clear = 1'b0;
         checks++; if (busy !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL stop_clear dir=%b busy=%b halted=%b expected 0 0", codes[k], busy, halted); end
         $display("stop dir=%b: halted then cleared", codes[k]);
      end
   endtask

   task automatic test_abort;
      int d0;
      d0 = doneCount;
      startMan(DIR_STRAIGHT);
      tick(1);
      abort = 1'b1;
      #1;
      checks++; if (motL !== MOT_BRAKE || motR !== MOT_BRAKE || spdSel !== SPD_OFF || busy !== 1'b1) begin failures++; $display("FAIL abort_clear mot=%b/%b spd=%b busy=%b expected 11/11 00 1", motL, motR, spdSel, busy); end
      tick(1);
      abort = 1'b0;
      checks++; if (busy !== 1'b0 || motL !== MOT_COAST) begin failures++; $display("FAIL abort_clear_idle busy=%b motL=%b expected 0 00", busy, motL); end
      startMan(DIR_RIGHT);
      pulses(20, 20);
      tick(1);
      pulses(39, 39);
      shaftPulseL = 1'b1;
      shaftPulseR = 1'b1;
      tick(2);
      shaftPulseL = 1'b0;
      shaftPulseR = 1'b0;
      tick(2);
      checks++; if (spdSel !== SPD_NINETY_FAST || motL !== MOT_BRAKE || motR !== MOT_BRAKE) begin failures++; $display("FAIL abort_pre spd=%b mot=%b/%b expected 11 11/11", spdSel, motL, motR); end
      abort = 1'b1;
      start = 1'b1;
      dir   = DIR_STRAIGHT;
      #1;
      checks++; if (spdSel !== SPD_OFF || busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL abort_rotate spd=%b busy=%b done=%b expected 00 1 0", spdSel, busy, done); end
      tick(1);
      abort = 1'b0;
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle busy=%b expected=0", busy); end
      tick(12);
      checks++; if (busy !== 1'b0 || doneCount != d0) begin failures++; $display("FAIL abort_nodone busy=%b done_pulses=%0d expected 0 0", busy, doneCount - d0); end
      $display("abort: done pulses=%0d", doneCount - d0);
   endtask

   task automatic test_busy_ignore;
      startMan(DIR_LEFT);
      start = 1'b1;
      dir   = DIR_RIGHT;
      tick(1);
      start = 1'b0;
      checks++; if (busy !== 1'b1 || motL !== MOT_FWD) begin failures++; $display("FAIL ignore_clear busy=%b motL=%b expected 1 01", busy, motL); end
      pulses(20, 20);
      tick(1);
      checks++; if (motL !== MOT_REV || motR !== MOT_FWD) begin failures++; $display("FAIL ignore_dir mot=%b/%b expected 10/01", motL, motR); end
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      $display("busy-ignore: rotate mot=%b/%b kept", motL, motR);
   endtask

   task automatic test_watchdog;
      int t0;
      t0 = timeoutCount;
      startMan(DIR_STRAIGHT);
`ifdef JUNCTION_SEQ_TIMEOUT_EN
      tick(998);
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL wd_early timeout=%b expected=0", timeout); end
      tick(1);
      checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL wd_pulse timeout=%b expected=1", timeout); end
      tick(1);
      checks++; if (timeout !== 1'b0 || spdSel !== SPD_OFF || motL !== MOT_BRAKE) begin failures++; $display("FAIL wd_settle timeout=%b spd=%b motL=%b expected 0 00 11", timeout, spdSel, motL); end
      tick(8);
      checks++; if (halted !== 1'b1 || timeoutCount != t0 + 1) begin failures++; $display("FAIL wd_halt halted=%b timeouts=%0d expected 1 1", halted, timeoutCount - t0); end
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
`else
      tick(2000);
      checks++; if (busy !== 1'b1 || motL !== MOT_FWD) begin failures++; $display("FAIL wd_off_stall busy=%b motL=%b expected 1 01", busy, motL); end
      checks++; if (timeoutCount != t0) begin failures++; $display("FAIL wd_off_timeout pulses=%0d expected=0", timeoutCount - t0); end
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
`endif
      $display("watchdog: timeouts=%0d busy=%b", timeoutCount - t0, busy);
   endtask

   task automatic test_reset_mid;
      startMan(DIR_STRAIGHT);
      tick(3);
      checks++; if (motL !== MOT_FWD) begin failures++; $display("FAIL rstmid_pre motL=%b expected=01", motL); end
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || {motL, motR, spdSel} !== 6'b0) begin failures++; $display("FAIL rstmid_async busy=%b outs=%b expected 0 000000", busy, {motL, motR, spdSel}); end
      #2;
      rst_n = 1'b1;
      tick(2);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle busy=%b expected=0", busy); end
      $display("reset-mid: busy=%b", busy);
   endtask

   initial begin
      test_reset;
      test_straight;
      test_left;
      test_back_skew;
      test_stop_invalid;
      test_abort;
      test_busy_ignore;
      test_watchdog;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
